npu_requant_accum: RTL
======================

# npu_requant_accum

Output stage downstream of the NPU 16-MAC dot-product unit. It accumulates a configured number of 32-bit partial sums (one per 16-element chunk) plus a bias into one neuron pre-activation. It then applies round-half-up arithmetic right shift, optional ReLU and INT8 saturation, and presents the result on a valid/ready stream to the activation buffer writer. The dot-product unit has no backpressure, so this block exports `busy` for the NPU controller to gate `enable`.

## Interface
- `PSUM_W`, 32, width of incoming partial sum (signed)
- `ACC_W`, 41, internal accumulator width (PSUM_W + 9; covers 255 chunks plus bias and rounding without wrap)
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge
- `cfg_start` in 1: one-cycle pulse; begins a new neuron and latches all `cfg_*` inputs
- `cfg_num_chunks` in 8: partial sums to accumulate; 0 is treated as 1
- `cfg_bias` in 32: signed bias, sign-extended into accumulator at start
- `cfg_shift` in 5: arithmetic right-shift amount, 0..31
- `cfg_relu` in 1: clamp negative results to 0
- `psum` in PSUM_W: signed partial sum from dot-product unit
- `psum_valid` in 1: `psum` is valid this cycle (one-cycle pulse per chunk)
- `out_data` out 8: signed INT8 result
- `out_sat` out 1: sideband; result was clipped to 127 or -128
- `out_valid` out 1: result available; held until accepted
- `out_ready` in 1: downstream accept
- `busy` out 1: high in every state except IDLE
- `err_drop` out 1: sticky; a `psum_valid` or `cfg_start` was ignored

## Operation
- States: IDLE, ACCUM, QUANT, OUTPUT.
- IDLE → ACCUM on `cfg_start`:
  - acc ← sext(cfg_bias)
  - remaining ← max(cfg_num_chunks, 1)
  - latch shift and relu.
- ACCUM, each `psum_valid`:
  - acc ← acc + sext(psum)
  - remaining decrements
  - when remaining reaches 0 after this add → QUANT.
  - Cycles without `psum_valid` wait indefinitely; there is no timeout.
- QUANT: one cycle, registers the quantized result, then → OUTPUT.
  - Rounding: r = (shift == 0) ? acc : (acc + (1 << (shift−1))) >>> shift, computed at ACC_W.
  - ReLU: if relu and r < 0, r = 0.
  - Saturation: r > 127 → 127 with sat=1; r < −128 → −128 with sat=1; otherwise sat=0.
- OUTPUT: `out_valid`=1 and `out_data`/`out_sat` stay stable until `out_valid && out_ready`.
  - On handshake → IDLE.
  - If `cfg_start` is high in the same handshake cycle, it is accepted and the next state is ACCUM.
- `psum_valid` in IDLE, QUANT or OUTPUT: data is dropped and `err_drop` is set.
- `cfg_start` in ACCUM, QUANT, or OUTPUT without handshake: ignored and `err_drop` is set.
- Simultaneous `cfg_start` and `psum_valid` in IDLE: start is accepted, psum is dropped, `err_drop` is set.
- `err_drop` clears only on reset.

## Timing
- Reset values: state IDLE; `out_data`=0, `out_sat`=0, `out_valid`=0, `busy`=0, `err_drop`=0; acc and counter 0.
- Reset during any state aborts the operation; the block is IDLE the cycle after `rst_n` is sampled low.
- `busy` rises the cycle after an accepted `cfg_start`.
- Latency: last `psum_valid` at cycle N → QUANT at N+1 → `out_valid`=1 at N+2.
- Minimum neuron period with `out_ready` tied high: chunks + 2 cycles, because start can overlap the handshake cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `npu_pkg`:
  - state enum `requant_state_t`
  - `PSUM_W`, `ACC_W`
  - INT8 limits `INT8_MAX`=127, `INT8_MIN`=−128
- Sub-module `npu_requant_sat`: purely combinational round/shift/ReLU/saturate (acc, shift, relu → data, sat). It is instantiated once and its output is registered in QUANT.
- The FSM, accumulator and output register live in the top module.

## Test plan
- chunks=1, bias=0, shift=0, relu=0, psum=100 → `out_data`=100, `out_sat`=0, `out_valid` exactly 2 cycles after `psum_valid`.
- chunks=3, bias=12, shift=5, psums 1000, 2000, −500 with gaps between them → acc 2512, output 79 (78.5 rounds up), sat=0.
- Saturation and ReLU, each with chunks=1, shift=0:
  - psum 50000, relu=0 → 127, sat=1
  - psum −50000, relu=0 → −128 (0x80), sat=1
  - psum −50000, relu=1 → 0, sat=0
- Backpressure: `out_ready`=0 for 5 cycles with a stray `psum_valid` and a `cfg_start` during that window.
  - `out_data` stays stable throughout.
  - `err_drop`=1 and stays 1.
  - Value is accepted once `out_ready` rises; the block then returns to IDLE.
- Back-to-back and zero-chunk:
  - `cfg_start` in the handshake cycle with chunks=0 → one psum (−7, bias 0, shift 0, relu=1) yields 0.
  - `busy` never drops between the two neurons.
- Reset mid-ACCUM: drop `rst_n` after 2 of 3 psums → all outputs at reset values the next cycle. A fresh 1-chunk run with psum=5 then outputs 5 with no residue from the aborted run.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: requantizer FSM states, datapath widths and INT8 limits.
package npu_pkg;

    // Width of one signed partial sum from the 16-MAC dot-product unit.
    localparam int PSUM_W = 32;

    // Accumulator width: headroom for 255 chunks plus bias and the rounding half-LSB.
    localparam int ACC_W = PSUM_W + 9;

    // Signed INT8 clipping limits.
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Requantizer control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_QUANT  = 2'd2,
        ST_OUTPUT = 2'd3
    } requant_state_t;

endpackage

// File: rtl/npu_requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional ReLU,
// then saturation of the wide accumulator to signed INT8 with a clip flag.
module npu_requant_sat #(
    parameter int ACC_W = npu_pkg::ACC_W
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [4:0]       i_shift,
    input  logic                    i_relu,
    output logic signed [7:0]       o_data,
    output logic                    o_sat
);

    localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'(npu_pkg::INT8_MAX);
    localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'(npu_pkg::INT8_MIN);

    logic signed [ACC_W-1:0] w_half;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [ACC_W-1:0] w_relu;

    // Round, shift, rectify and clip in one combinational pass.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        w_half    = '0;
        w_sum     = '0;
        w_shifted = '0;
        w_relu    = '0;
        o_data    = '0;
        o_sat     = 1'b0;

        // Adding half an output LSB before flooring gives round-half-up; shift 0 adds nothing.
        if (i_shift != 5'd0) begin
            w_half = ACC_W'(1) << (i_shift - 5'd1);
        end
        w_sum     = i_acc + w_half;
        w_shifted = w_sum >>> i_shift;

        w_relu = (i_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;

        if (w_relu > L_MAX) begin
            o_data = 8'(npu_pkg::INT8_MAX);
            o_sat  = 1'b1;
        end else if (w_relu < L_MIN) begin
            o_data = 8'(npu_pkg::INT8_MIN);
            o_sat  = 1'b1;
        end else begin
            o_data = w_relu[7:0];
            o_sat  = 1'b0;
        end
    end

endmodule

// File: rtl/npu_requant_accum.sv
// Output stage after the dot-product unit: accumulates a configured number of
// partial sums onto a bias, requantizes to INT8 and hands the result out on a
// valid/ready stream. busy lets the controller gate the non-stallable MAC array.
module npu_requant_accum
    import npu_pkg::*;
#(
    parameter int PSUM_W = npu_pkg::PSUM_W,
    parameter int ACC_W  = npu_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic        [7:0]        cfg_num_chunks,
    input  logic signed [31:0]       cfg_bias,
    input  logic        [4:0]        cfg_shift,
    input  logic                     cfg_relu,
    input  logic signed [PSUM_W-1:0] psum,
    input  logic                     psum_valid,
    output logic signed [7:0]        out_data,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     err_drop
);

    requant_state_t          r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic        [7:0]       r_remaining;
    logic        [4:0]       r_shift;
    logic                    r_relu;
    logic signed [7:0]       r_out_data;
    logic                    r_out_sat;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    r_err_drop;

    logic        [7:0]       w_start_chunks;
    logic signed [7:0]       w_q_data;
    logic                    w_q_sat;

    // A zero chunk count still consumes one partial sum.
    assign w_start_chunks = (cfg_num_chunks == 8'd0) ? 8'd1 : cfg_num_chunks;

    npu_requant_sat #(
        .ACC_W (ACC_W)
    ) u_sat (
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .i_relu  (r_relu),
        .o_data  (w_q_data),
        .o_sat   (w_q_sat)
    );

    // Control FSM, accumulator and registered output stage.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator and counter are few flops, so they are reset along with control to leave no residue after an abort.
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err_drop  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_acc       <= ACC_W'(cfg_bias);
                        r_remaining <= w_start_chunks;
                        r_shift     <= cfg_shift;
                        r_relu      <= cfg_relu;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end
                    if (psum_valid) begin
                        r_err_drop <= 1'b1;
                    end
                end

                ST_ACCUM: begin
                    if (psum_valid) begin
                        r_acc       <= r_acc + ACC_W'(psum);
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            r_state <= ST_QUANT;
                        end
                    end
                    if (cfg_start) begin
                        r_err_drop <= 1'b1;
                    end
                end

                ST_QUANT: begin
                    r_out_data  <= w_q_data;
                    r_out_sat   <= w_q_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUTPUT;
                    if (psum_valid || cfg_start) begin
                        r_err_drop <= 1'b1;
                    end
                end

                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        // A start in the handshake cycle chains the next neuron without an idle gap.
                        if (cfg_start) begin
                            r_acc       <= ACC_W'(cfg_bias);
                            r_remaining <= w_start_chunks;
                            r_shift     <= cfg_shift;
                            r_relu      <= cfg_relu;
                            r_state     <= ST_ACCUM;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (cfg_start) begin
                        r_err_drop <= 1'b1;
                    end
                    if (psum_valid) begin
                        r_err_drop <= 1'b1;
                    end
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign err_drop  = r_err_drop;

endmodule
